// File: rtl/loader_pkg.sv
// Shared types and constants for the boot image loader.
package loader_pkg;

  typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, DONE} loader_state_t;

  localparam int unsigned LEN_BYTES  = 4;
  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// Four-lane little-endian byte-to-word assembler with byte-enable accumulation.
module byte_packer
  import loader_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clear_i,
  input  logic                      push_i,
  input  logic [7:0]                byte_i,
  output logic [1:0]                lane_o,
  output logic [8*WORD_BYTES-1:0]   word_o,
  output logic [WORD_BYTES-1:0]     be_o
);

  logic [1:0]              lane_q;
  logic [8*WORD_BYTES-1:0] word_q;
  logic [WORD_BYTES-1:0]   be_q;

  assign lane_o = lane_q;

  // word_o/be_o already include the byte being pushed this cycle, so the
  // caller can latch a complete word on the same edge the last lane arrives.
  always_comb begin
    word_o = word_q;
    be_o   = be_q;
    if (push_i) begin
      word_o[8*lane_q +: 8] = byte_i;
      be_o[lane_q]          = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i || clear_i) begin
      lane_q <= '0;
      word_q <= '0;
      be_q   <= '0;
    end else if (push_i) begin
      lane_q <= lane_q + 2'd1;
      word_q <= word_o;
      be_q   <= be_o;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Boot loader: receives a length-prefixed byte image and writes it as
// little-endian words into instruction memory, holding the core in reset.
module instr_mem_loader
  import loader_pkg::*;
#(
  parameter int unsigned MEM_SIZE  = 1024,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  output logic        core_rst_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam logic [31:0] BASE  = 32'(BASE_ADDR);
  localparam logic [31:0] LIMIT = 32'(MEM_SIZE - BASE_ADDR);

  loader_state_t state_q;
  logic [31:0]   len_q;
  logic [31:0]   load_len_q;
  logic [1:0]    hdr_cnt_q;
  logic [31:0]   byte_cnt_q;
  logic [29:0]   word_idx_q;

  logic          byte_ready_q;
  logic          mem_we_q;
  logic [31:0]   mem_addr_q;
  logic [31:0]   mem_wdata_q;
  logic [3:0]    mem_be_q;
  logic          core_rst_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;

  logic          accept;
  logic          push;
  logic          pk_clear;
  logic [31:0]   len_next;
  logic [31:0]   byte_cnt_inc;
  logic [1:0]    pk_lane;
  logic [31:0]   pk_word;
  logic [3:0]    pk_be;

  assign accept       = byte_valid_i && byte_ready_q;
  assign len_next     = {byte_i, len_q[31:8]};
  assign byte_cnt_inc = byte_cnt_q + 32'd1;
  // Bytes beyond the memory limit are acknowledged but never reach the packer.
  assign push         = (state_q == DATA) && accept && (byte_cnt_q < load_len_q);
  assign pk_clear     = (state_q == WRITE);

  byte_packer u_packer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (pk_clear),
    .push_i  (push),
    .byte_i  (byte_i),
    .lane_o  (pk_lane),
    .word_o  (pk_word),
    .be_o    (pk_be)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      len_q        <= '0;
      load_len_q   <= '0;
      hdr_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      word_idx_q   <= '0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= BASE;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      core_rst_q   <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q      <= LEN;
          byte_ready_q <= 1'b1;
          busy_q       <= 1'b1;
        end
        LEN: begin
          if (accept) begin
            len_q     <= len_next;
            hdr_cnt_q <= hdr_cnt_q + 2'd1;
            if (hdr_cnt_q == 2'(LEN_BYTES - 1)) begin
              err_q      <= (len_next > LIMIT);
              load_len_q <= (len_next > LIMIT) ? LIMIT : len_next;
              if (len_next == '0) begin
                state_q      <= DONE;
                byte_ready_q <= 1'b0;
                busy_q       <= 1'b0;
                core_rst_q   <= 1'b0;
                done_q       <= 1'b1;
              end else begin
                state_q <= DATA;
              end
            end
          end
        end
        DATA: begin
          if (accept) begin
            byte_cnt_q <= byte_cnt_inc;
            if (push) begin
              if (pk_lane == 2'd3 || byte_cnt_inc == load_len_q) begin
                state_q      <= WRITE;
                byte_ready_q <= 1'b0;
                mem_we_q     <= 1'b1;
                mem_addr_q   <= BASE + {word_idx_q, 2'b00};
                mem_wdata_q  <= pk_word;
                mem_be_q     <= pk_be;
              end
            end else if (byte_cnt_inc == len_q) begin
              state_q      <= DONE;
              byte_ready_q <= 1'b0;
              busy_q       <= 1'b0;
              core_rst_q   <= 1'b0;
              done_q       <= 1'b1;
            end
          end
        end
        WRITE: begin
          mem_we_q    <= 1'b0;
          mem_wdata_q <= '0;
          mem_be_q    <= '0;
          word_idx_q  <= word_idx_q + 30'd1;
          if (byte_cnt_q == len_q) begin
            state_q    <= DONE;
            busy_q     <= 1'b0;
            core_rst_q <= 1'b0;
            done_q     <= 1'b1;
          end else begin
            state_q      <= DATA;
            byte_ready_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign byte_ready_o = byte_ready_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign mem_be_o     = mem_be_q;
  assign core_rst_o   = core_rst_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: expected writes are queued by the
// stimulus and checked by an independent write monitor.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        core_rst;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  instr_mem_loader #(.MEM_SIZE(1024), .BASE_ADDR(0)) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .byte_i       (byte_in),
    .byte_valid_i (byte_valid),
    .byte_ready_o (byte_ready),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_be_o     (mem_be),
    .core_rst_o   (core_rst),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  wr_t         exp_q[$];
  int          pass_cnt  = 0;
  int          total_cnt = 0;
  int          wr_cnt    = 0;
  int          ack_cnt   = 0;
  logic [31:0] last_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Write monitor
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_cnt++;
      last_addr = mem_addr;
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_write: got addr %h data %h be %h expected none",
                 mem_addr, mem_wdata, mem_be);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", mem_addr, e.addr);
        chk("wr_data", mem_wdata, e.data);
        chk("wr_be", {28'd0, mem_be}, {28'd0, e.be});
      end
    end
  end

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_t e;
    e.addr = a; e.data = d; e.be = be;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    byte_valid = 1'b0;
    byte_in    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_be", {28'd0, mem_be}, 32'd0);
    chk("rst_core_rst", {31'd0, core_rst}, 32'd1);
    chk("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int n;
    while (rnd && $urandom_range(0, 99) >= 30) begin
      byte_valid = 1'b0;
      @(posedge clk); #1;
    end
    byte_in    = b;
    byte_valid = 1'b1;
    n = 0;
    while (byte_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (byte_ready !== 1'b1) begin
      total_cnt++;
      $display("FAIL send_timeout: got ready=%b expected 1 within 50 cycles", byte_ready);
    end else begin
      @(posedge clk); #1;
      ack_cnt++;
    end
    byte_valid = 1'b0;
  endtask

  task automatic send_len(input logic [31:0] n, input bit rnd);
    for (int unsigned i = 0; i < 4; i++) send_byte(n[8*i +: 8], rnd);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done", {31'd0, done}, 32'd1);
  endtask

  logic [7:0] img8[8];
  int         wr_snap;

  initial begin
    img8[0] = 8'h13; img8[1] = 8'h05; img8[2] = 8'h00; img8[3] = 8'h00;
    img8[4] = 8'h93; img8[5] = 8'h05; img8[6] = 8'h10; img8[7] = 8'h00;

    // Length 8, back-to-back, with done timing after the 2nd write
    do_reset();
    push_exp(32'h0, 32'h00000513, 4'hF);
    push_exp(32'h4, 32'h00100593, 4'hF);
    send_len(32'd8, 1'b0);
    for (int i = 0; i < 8; i++) send_byte(img8[i], 1'b0);
    chk("t1_write_we", {31'd0, mem_we}, 32'd1);
    chk("t1_write_ready", {31'd0, byte_ready}, 32'd0);
    chk("t1_write_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_core_rst", {31'd0, core_rst}, 32'd0);
    chk("t1_err", {31'd0, err}, 32'd0);
    chk("t1_busy", {31'd0, busy}, 32'd0);
    chk("t1_drained", exp_q.size(), 32'd0);

    // Length 6, partial last word
    do_reset();
    push_exp(32'h0, 32'hDDCCBBAA, 4'hF);
    push_exp(32'h4, 32'h00002211, 4'h3);
    send_len(32'd6, 1'b0);
    send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0); send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b0); send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
    wait_done(20);
    chk("t2_err", {31'd0, err}, 32'd0);
    chk("t2_drained", exp_q.size(), 32'd0);

    // Length 0: done right after the header, later bytes not acknowledged
    do_reset();
    wr_snap = wr_cnt;
    send_len(32'd0, 1'b0);
    chk("t3_done", {31'd0, done}, 32'd1);
    byte_in = 8'h55; byte_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t3_ready_low", {31'd0, byte_ready}, 32'd0);
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    chk("t3_no_write", wr_cnt, wr_snap);
    chk("t3_core_rst", {31'd0, core_rst}, 32'd0);

    // Oversized image: 1028 bytes into 1024-byte memory
    do_reset();
    wr_cnt = 0; ack_cnt = 0;
    for (int i = 0; i < 256; i++)
      push_exp(32'(4 * i), {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, 4'hF);
    send_len(32'd1028, 1'b0);
    for (int j = 0; j < 1028; j++) send_byte(8'(j), 1'b0);
    wait_done(20);
    chk("t4_acks", ack_cnt, 32'd1032);
    chk("t4_err", {31'd0, err}, 32'd1);
    chk("t4_writes", wr_cnt, 32'd256);
    chk("t4_last_addr", last_addr, 32'h3FC);
    chk("t4_drained", exp_q.size(), 32'd0);

    // Length 12 with ~30% valid duty
    do_reset();
    wr_cnt = 0;
    push_exp(32'h0, 32'h04030201, 4'hF);
    push_exp(32'h4, 32'h08070605, 4'hF);
    push_exp(32'h8, 32'h0C0B0A09, 4'hF);
    send_len(32'd12, 1'b1);
    for (int j = 1; j <= 12; j++) send_byte(8'(j), 1'b1);
    wait_done(20);
    chk("t5_writes", wr_cnt, 32'd3);
    chk("t5_drained", exp_q.size(), 32'd0);

    // Reset after 5 payload bytes, then full resend
    do_reset();
    push_exp(32'h0, 32'h00000513, 4'hF);
    send_len(32'd8, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(img8[i], 1'b0);
    chk("t6_pre_abort_drained", exp_q.size(), 32'd0);
    do_reset();
    wr_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_no_stale_write", wr_cnt, 32'd0);
    push_exp(32'h0, 32'h00000513, 4'hF);
    push_exp(32'h4, 32'h00100593, 4'hF);
    send_len(32'd8, 1'b0);
    for (int i = 0; i < 7; i++) send_byte(img8[i], 1'b0);
    chk("t6_core_rst_held", {31'd0, core_rst}, 32'd1);
    send_byte(img8[7], 1'b0);
    wait_done(20);
    chk("t6_core_rst_released", {31'd0, core_rst}, 32'd0);
    chk("t6_writes", wr_cnt, 32'd2);
    chk("t6_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
